// File: rtl/imem_pipelined.sv
// Word-addressed instruction memory for the fetch stage: 1- or 2-stage read
// pipeline with valid/ready handshakes, flush, program-load port and fault codes.
module imem_pipelined #(
   parameter int          ADDR_W    = 32,
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 1,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_instr,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [1:0]        rsp_fault,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int IW    = ADDR_W - 2;

   typedef enum logic [1:0] {
      FLT_OK       = 2'b00,
      FLT_MISALIGN = 2'b01,
      FLT_RANGE    = 2'b10
   } fault_t;

   // Boot image; contents survive rst, only the pipeline is cleared.
   logic [31:0] mem [DEPTH] = '{
      0: 32'h0050_0093,
      1: 32'h00A0_0113,
      2: 32'h0020_81B3,
      3: 32'h0640_0213,
      4: 32'h0032_2023,
      5: 32'h0002_2283,
      default: '0
   };

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic             req_oor, wr_oor;
   logic             unused_wr_lsb;

   assign unused_wr_lsb = ^wr_addr[1:0];

   generate
      if (IW > IDX_W) begin : g_range
         assign req_oor = |req_addr[ADDR_W-1:IDX_W+2];
         assign wr_oor  = |wr_addr[ADDR_W-1:IDX_W+2];
         assign rd_idx  = req_addr[IDX_W+1:2];
         assign wr_idx  = wr_addr[IDX_W+1:2];
      end else begin : g_full
         assign req_oor = 1'b0;
         assign wr_oor  = 1'b0;
         assign rd_idx  = IDX_W'(req_addr[ADDR_W-1:2]);
         assign wr_idx  = IDX_W'(wr_addr[ADDR_W-1:2]);
      end
   endgenerate

   fault_t req_fault;

   always_comb begin
      req_fault = FLT_OK;
      if (|req_addr[1:0])
         req_fault = FLT_MISALIGN;
      else if (req_oor)
         req_fault = FLT_RANGE;
   end

   // Read-first: the fetch below samples mem before this write lands.
   always_ff @(posedge clk) begin
      if (wr_en && !wr_oor)
         mem[wr_idx] <= wr_data;
   end

   logic              s0_valid;
   logic [ADDR_W-1:0] s0_addr;
   fault_t            s0_fault;
   logic [31:0]       s0_instr;
   logic              adv_first;
   logic              req_fire;

   assign req_ready = rst && !flush && adv_first;
   assign req_fire  = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_valid <= 1'b0;
         s0_addr  <= '0;
         s0_fault <= FLT_OK;
         s0_instr <= '0;
      end else if (flush) begin
         s0_valid <= 1'b0;
      end else if (adv_first) begin
         s0_valid <= req_fire;
         if (req_fire) begin
            s0_addr  <= req_addr;
            s0_fault <= req_fault;
            s0_instr <= (req_fault == FLT_OK) ? mem[rd_idx] : NOP_INSTR;
         end
      end
   end

   generate
      if (LATENCY == 1) begin : g_lat1
         assign adv_first = !s0_valid || rsp_ready;
         assign rsp_valid = s0_valid;
         assign rsp_instr = s0_instr;
         assign rsp_addr  = s0_addr;
         assign rsp_fault = s0_fault;
      end else begin : g_lat2
         logic              s1_valid;
         logic [ADDR_W-1:0] s1_addr;
         fault_t            s1_fault;
         logic [31:0]       s1_instr;
         logic              adv_last;

         // Stage 0 may move whenever stage 1 is empty or draining this cycle.
         assign adv_last  = !s1_valid || rsp_ready;
         assign adv_first = !s0_valid || adv_last;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               s1_valid <= 1'b0;
               s1_addr  <= '0;
               s1_fault <= FLT_OK;
               s1_instr <= '0;
            end else if (flush) begin
               s1_valid <= 1'b0;
            end else if (adv_last) begin
               s1_valid <= s0_valid;
               if (s0_valid) begin
                  s1_addr  <= s0_addr;
                  s1_fault <= s0_fault;
                  s1_instr <= s0_instr;
               end
            end
         end

         assign rsp_valid = s1_valid;
         assign rsp_instr = s1_instr;
         assign rsp_addr  = s1_addr;
         assign rsp_fault = s1_fault;
      end
   endgenerate

endmodule

// File: tb/tb_imem_pipelined.sv
// Scoreboard bench for imem_pipelined: LATENCY=1 and LATENCY=2 instances share
// stimulus; a queue-per-instance model predicts every response and req_ready.
module tb_imem_pipelined;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_valid, rsp_ready, flush, wr_en;
   logic [31:0] req_addr, wr_addr, wr_data;
   logic        rdy [2];
   logic        vld [2];
   logic [31:0] ins [2];
   logic [31:0] rad [2];
   logic [1:0]  flt [2];

   imem_pipelined #(.ADDR_W(32), .DEPTH(1024), .LATENCY(1), .NOP_INSTR(NOP)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
      .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_instr(ins[0]), .rsp_addr(rad[0]),
      .rsp_fault(flt[0]), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   imem_pipelined #(.ADDR_W(32), .DEPTH(1024), .LATENCY(2), .NOP_INSTR(NOP)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
      .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_instr(ins[1]), .rsp_addr(rad[1]),
      .rsp_fault(flt[1]), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (latency %0d) @%0t: got %h, expected %h", name, k + 1, $time, act, exp);
      end
   endtask

   // Reference model: word memory plus an in-flight list per instance with ages.
   logic [31:0] ref_mem [1024];
   logic [31:0] q_instr [2][4];
   logic [31:0] q_addr  [2][4];
   logic [1:0]  q_fault [2][4];
   int          q_age   [2][4];
   int          q_cnt   [2];

   function automatic void expect_fetch(input logic [31:0] a, output logic [31:0] i, output logic [1:0] f);
      if (a[1:0] != 2'b00) begin
         f = 2'b01; i = NOP;
      end else if ((a >> 2) >= 32'd1024) begin
         f = 2'b10; i = NOP;
      end else begin
         f = 2'b00; i = ref_mem[a[11:2]];
      end
   endfunction

   function automatic logic [31:0] rand_addr();
      int unsigned sel = $urandom_range(0, 9);
      if (sel < 6) return 32'($urandom_range(0, 31)) << 2;
      if (sel == 6) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      if (sel == 7) return 32'($urandom_range(1024, 1 << 20)) << 2;
      return 32'($urandom_range(0, 1023)) << 2;
   endfunction

   // Monitor / scoreboard: compare what is presented, then advance the model
   // by what the coming edge will do with the inputs now applied.
   initial begin
      int lat;
      bit present, exp_rdy, pop, fire;
      logic [31:0] ei;
      logic [1:0]  ef;
      q_cnt[0] = 0;
      q_cnt[1] = 0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            lat = k + 1;
            if (!rst) begin
               check("reset rsp_valid", k, 32'(vld[k]), 32'd0);
               check("reset req_ready", k, 32'(rdy[k]), 32'd0);
               check("reset rsp_instr", k, ins[k], 32'd0);
               check("reset rsp_addr",  k, rad[k], 32'd0);
               check("reset rsp_fault", k, 32'(flt[k]), 32'd0);
               q_cnt[k] = 0;
               continue;
            end
            present = (q_cnt[k] > 0) && (q_age[k][0] >= lat);
            exp_rdy = !flush && ((q_cnt[k] < lat) || rsp_ready);
            check("rsp_valid", k, 32'(vld[k]), 32'(present));
            check("req_ready", k, 32'(rdy[k]), 32'(exp_rdy));
            if (present && vld[k]) begin
               check("rsp_instr", k, ins[k], q_instr[k][0]);
               check("rsp_addr",  k, rad[k], q_addr[k][0]);
               check("rsp_fault", k, 32'(flt[k]), 32'(q_fault[k][0]));
            end
            pop  = present && rsp_ready;
            fire = exp_rdy && req_valid;
            if (flush) begin
               q_cnt[k] = 0;
            end else begin
               if (pop) begin
                  for (int j = 0; j < 3; j++) begin
                     q_instr[k][j] = q_instr[k][j+1];
                     q_addr[k][j]  = q_addr[k][j+1];
                     q_fault[k][j] = q_fault[k][j+1];
                     q_age[k][j]   = q_age[k][j+1];
                  end
                  q_cnt[k]--;
               end
               for (int j = 0; j < q_cnt[k]; j++) q_age[k][j]++;
               if (fire) begin
                  expect_fetch(req_addr, ei, ef);
                  q_instr[k][q_cnt[k]] = ei;
                  q_addr[k][q_cnt[k]]  = req_addr;
                  q_fault[k][q_cnt[k]] = ef;
                  q_age[k][q_cnt[k]]   = 1;
                  q_cnt[k]++;
               end
            end
         end
         if (wr_en && wr_addr[31:12] == 20'd0) ref_mem[wr_addr[11:2]] = wr_data;
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_req(input logic v, input logic [31:0] a);
      req_valid = v;
      req_addr  = a;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      ref_mem[0] = 32'h0050_0093;
      ref_mem[1] = 32'h00A0_0113;
      ref_mem[2] = 32'h0020_81B3;
      ref_mem[3] = 32'h0640_0213;
      ref_mem[4] = 32'h0032_2023;
      ref_mem[5] = 32'h0002_2283;

      rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      step(2);
      rst = 1'b1;

      // Back-to-back fetches with no back-pressure
      rsp_ready = 1'b1;
      set_req(1'b1, 32'h0); step();
      set_req(1'b1, 32'h4); step();
      set_req(1'b1, 32'h8); step();
      set_req(1'b0, 32'h0); step(3);

      // Back-pressure: stall three cycles behind 0xC
      set_req(1'b1, 32'hC); step();
      rsp_ready = 1'b0;
      set_req(1'b1, 32'h10); step(3);
      rsp_ready = 1'b1;
      set_req(1'b0, 32'h0); step(4);

      // Faults: misaligned then out of range
      set_req(1'b1, 32'h6); step();
      set_req(1'b1, 32'h2000); step();
      set_req(1'b0, 32'h0); step(3);

      // Same-cycle write and fetch are read-first
      wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'hDEAD_BEEF;
      set_req(1'b1, 32'h14); step();
      wr_en = 1'b0;
      set_req(1'b1, 32'h14); step();
      set_req(1'b0, 32'h0); step(3);

      // Flush with two fetches in flight and a request pending
      rsp_ready = 1'b0;
      set_req(1'b1, 32'h0); step();
      set_req(1'b1, 32'h4); step();
      flush = 1'b1;
      set_req(1'b1, 32'h8); step();
      flush = 1'b0;
      rsp_ready = 1'b1;
      step(); set_req(1'b0, 32'h0); step(3);

      // Asynchronous reset between clock edges
      rsp_ready = 1'b0;
      set_req(1'b1, 32'h4); step();
      set_req(1'b1, 32'h8); step();
      #2 rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("async reset rsp_valid", k, 32'(vld[k]), 32'd0);
         check("async reset rsp_instr", k, ins[k], 32'd0);
         check("async reset rsp_addr",  k, rad[k], 32'd0);
         check("async reset rsp_fault", k, 32'(flt[k]), 32'd0);
         check("async reset req_ready", k, 32'(rdy[k]), 32'd0);
      end
      set_req(1'b0, 32'h0);
      step(2);
      rst = 1'b1;
      rsp_ready = 1'b1;
      set_req(1'b1, 32'h0); step();
      set_req(1'b1, 32'h14); step();
      set_req(1'b0, 32'h0); step(3);

      // Randomised traffic
      for (int c = 0; c < 1500; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_addr  = rand_addr();
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         wr_en     = ($urandom_range(0, 7) == 0);
         wr_addr   = ($urandom_range(0, 9) == 0) ? (32'($urandom_range(1024, 4096)) << 2)
                                                 : 32'($urandom_range(0, 127));
         wr_data   = $urandom;
         step();
      end

      req_valid = 1'b0; rsp_ready = 1'b1; flush = 1'b0; wr_en = 1'b0;
      step(6);
      for (int k = 0; k < 2; k++) check("drained", k, 32'(q_cnt[k]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_pipelined.md
Name: imem_pipelined

Overview:
- Parametrised synchronous instruction memory for the RISC-V pipeline fetch stage.
- Word-addressed storage with a configurable read latency of 1 or 2 cycles and valid/ready handshakes on both request and response.
- Adds a program-load write port, a flush for branch redirects, and fault reporting for misaligned and out-of-range fetches.

Parameters:
- ADDR_W, 32, byte-address width of fetch and load addresses.
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 1, read pipeline stages; only 1 or 2 are legal.
- NOP_INSTR, 32'h00000013, instruction returned on faults (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when high together with req_valid.
- req_addr  in  ADDR_W  fetch byte address (PC).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  32  fetched instruction.
- rsp_addr  out  ADDR_W  PC of the response.
- rsp_fault  out  2  fault code: 00 ok, 01 misaligned, 10 out-of-range.
- flush  in  1  discard all in-flight fetches.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  ADDR_W  program-load byte address.
- wr_data  in  32  program-load word.

Behaviour:
- Index is addr[ADDR_W-1:2].
- Pipeline structure:
  - Chain of LATENCY stages, each holding valid, addr, fault and instr.
  - The last stage drives the rsp_* outputs.
  - A stage advances when the next stage is empty or is advancing itself.
  - The last stage advances when rsp_ready is high or it is empty.
- Handshake:
  - req_ready = !flush && (stage0 empty || stage0 advancing).
  - A transfer occurs on req_valid && req_ready at the rising edge.
  - Response latency is exactly LATENCY cycles from acceptance to rsp_valid when there is no back-pressure.
  - Throughput is one fetch per cycle.
- Back-pressure:
  - While rsp_valid && !rsp_ready, rsp_instr, rsp_addr and rsp_fault hold stable and no stage loses data.
  - With LATENCY=2 the second stage buffers one in-flight fetch, so an access already issued is never lost.
- Faults:
  - req_addr[1:0] != 0 produces fault 01.
  - Otherwise, index >= DEPTH produces fault 10. This can only occur when ADDR_W-2 > log2(DEPTH).
  - A faulting response returns rsp_instr = NOP_INSTR, and the memory is not read.
  - Misaligned takes priority over out-of-range.
- Flush:
  - On the cycle flush is high, every stage valid bit is cleared at the next edge.
  - req_ready is 0 in that cycle, so a simultaneous request is not taken.
  - rsp_valid goes low the cycle after flush.
  - A response handshaked in the same cycle as flush still counts as delivered.
- Write port:
  - On wr_en the word at index wr_addr is written at the edge.
  - wr_addr[1:0] is ignored; an out-of-range wr_addr is ignored.
  - A write and a fetch to the same word in the same cycle are read-first: the fetch returns the old data.
  - Writes are independent of the handshake and of flush.
- Reset (rst=0):
  - Immediately and asynchronously clears all valid bits.
  - rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_fault=00, req_ready=0.
  - In-flight fetches are discarded and memory contents are retained.
  - After rst rises, req_ready=1 from the first clock.
- Power-up contents: mem[0..5] = 00500093, 00A00113, 002081B3, 06400213, 00322023, 00022283; all other words 0.

Test Plan:
- LATENCY=1: after reset, fetch 0x0, 0x4, 0x8 on back-to-back cycles with rsp_ready=1 -> rsp_instr 00500093, 00A00113, 002081B3 on consecutive cycles, each one cycle after its request, with rsp_fault=00.
- LATENCY=2, rsp_ready=0 for 3 cycles after request 0xC -> rsp_valid held with 06400213 and addr 0xC, req_ready=0 once both stages are full, no loss, and 0x10 then returns 00322023 after release.
- Fetch 0x6, then fetch 0x2000 with DEPTH=1024 -> rsp_fault 01 then 10, rsp_instr 00000013 for both.
- Same cycle: wr_en to 0x14 with DEADBEEF and fetch 0x14 -> returns 00022283; a second fetch of 0x14 returns DEADBEEF.
- Two fetches in flight (LATENCY=2) with flush asserted and req_valid=1 -> rsp_valid=0 the next cycle, the request is not accepted, and the next accepted fetch returns correctly.
- rst driven low mid-stream between clock edges -> rsp_valid drops immediately without a clock, outputs become 0, and after release a fetch of 0x0 returns 00500093.
